// File: rtl/ttd.sv
// Time-to-digital converter for an RC charge-time measurement.
// The capacitor is held discharged for a fixed number of clocks, then released.
// Clock cycles are counted until the synchronized comparator reports the threshold.
// If the counter's MSB sets before the threshold is seen, the result saturates to all ones.
// Conversions repeat back to back with no external trigger.
module ttd #(
  parameter int WIDTH            = 9,
  parameter int DISCHARGE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             rst_cap,
  output logic [WIDTH-2:0] register_out
);

  // Timer wide enough to hold DISCHARGE_CYCLES; it saturates there while waiting on in_s
  localparam int TW = $clog2(DISCHARGE_CYCLES + 1);
  localparam logic [TW-1:0]    TMR_MAX = TW'(DISCHARGE_CYCLES);
  localparam logic [TW-1:0]    TMR_ONE = TW'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic {
    S_DISCHARGE = 1'b0,
    S_COUNT     = 1'b1
  } state_e;

  state_e           state_q;
  logic             rst_cap_q;
  logic [TW-1:0]    tmr_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-2:0] result_q;
  logic             in_meta_q;
  logic             in_s;

  // Two-flop synchronizer for the asynchronous comparator output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_meta_q <= 1'b0;
      in_s      <= 1'b0;
    end else begin
      in_meta_q <= in;
      in_s      <= in_meta_q;
    end
  end

  // Conversion FSM: discharge/hold, then count until threshold or overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_DISCHARGE;
      rst_cap_q <= 1'b1;
      tmr_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_DISCHARGE: begin
          cnt_q <= '0;
          if ((tmr_q == TMR_MAX) && !in_s) begin
            // Discharge time met and comparator low: release the capacitor
            state_q   <= S_COUNT;
            rst_cap_q <= 1'b0;
          end else begin
            rst_cap_q <= 1'b1;
            if (tmr_q != TMR_MAX) begin
              tmr_q <= tmr_q + TMR_ONE;
            end else begin
              tmr_q <= tmr_q;
            end
          end
        end
        S_COUNT: begin
          if (cnt_q[WIDTH-1]) begin
            // Overflow wins even if the threshold arrives on this same edge
            result_q  <= '1;
            state_q   <= S_DISCHARGE;
            rst_cap_q <= 1'b1;
            tmr_q     <= '0;
            cnt_q     <= '0;
          end else if (in_s) begin
            result_q  <= cnt_q[WIDTH-2:0];
            state_q   <= S_DISCHARGE;
            rst_cap_q <= 1'b1;
            tmr_q     <= '0;
            cnt_q     <= '0;
          end else begin
            cnt_q     <= cnt_q + CNT_ONE;
            rst_cap_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_DISCHARGE;
          rst_cap_q <= 1'b1;
          tmr_q     <= '0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign rst_cap      = rst_cap_q;
  assign register_out = result_q;

endmodule

// File: tb/tb_ttd.sv
`timescale 1ns/100ps
module tb_ttd;

  localparam int WIDTH = 9;
  localparam int DC    = 8;
  localparam int TCLK  = 25;
  localparam int SAT   = (1 << (WIDTH - 1)) - 1;
  localparam int BOUND = 400;

  logic             clk;
  logic             rst;
  logic             in;
  logic             rst_cap;
  logic [WIDTH-2:0] register_out;

  int n_chk  = 0;
  int n_pass = 0;

  ttd #(.WIDTH(WIDTH), .DISCHARGE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .rst_cap      (rst_cap),
    .register_out (register_out)
  );

  initial begin
    clk = 1'b0;
    forever #12.5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    n_chk++;
    if ((obs < exp - tol) || (obs > exp + tol))
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
    else
      n_pass++;
  endtask

  // Reference: the count equals whole clock periods from release to the rise, plus
  // two synchronizer cycles, saturating at the all-ones code.
  function automatic int model(input int t_ns);
    int v;
    v = t_ns / TCLK + 2;
    if (v > SAT) v = SAT;
    return v;
  endfunction

  // Count rising edges until rst_cap reaches lvl (sampled 1 ns after each edge)
  task automatic wait_cap(input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((rst_cap !== lvl) && (n < BOUND));
  endtask

  // Entered 1 ns after the edge on which rst_cap fell; returns the same way
  task automatic conversion(input string tag, input int t_ns, input int tol);
    int n;
    int exp;
    exp = model(t_ns);
    #(t_ns - 1);
    in = 1'b1;
    wait_cap(1'b1, n);
    in = 1'b0;
    check({tag, "_result"}, int'(register_out), exp, tol);
    wait_cap(1'b0, n);
    check({tag, "_discharge_len"}, n, DC + 1, 1);
    check({tag, "_hold"}, int'(register_out), exp, tol);
  endtask

  initial begin
    int n;
    int k;
    int t;
    rst = 1'b1;
    in  = 1'b0;
    #50;
    check("reset_rst_cap", int'(rst_cap), 1, 0);
    check("reset_result", int'(register_out), 0, 0);
    #50;
    rst = 1'b0;
    wait_cap(1'b0, n);
    check("powerup_fall_delay", n, DC + 1, 0);

    conversion("short", 3260, 1);
    conversion("middle", 4305, 1);
    conversion("long", 5350, 1);

    for (int i = 252; i <= 254; i++)
      conversion($sformatf("edge_k%0d", i), i * TCLK + 10, 0);

    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(250, 1);
      t = k * TCLK + 3 + $urandom_range(19, 0);
      conversion($sformatf("rand%0d", i), t, 0);
    end

    // No threshold: counts out and saturates, then restarts by itself
    wait_cap(1'b1, n);
    check("nothresh_len", n, SAT + 2, 0);
    check("nothresh_result", int'(register_out), SAT, 0);
    wait_cap(1'b0, n);
    check("nothresh_restart", n, DC + 1, 0);

    // Comparator stuck high through discharge holds the capacitor discharged
    #100;
    in = 1'b1;
    wait_cap(1'b1, n);
    repeat (30) @(posedge clk);
    #1;
    check("stuck_hold", int'(rst_cap), 1, 0);
    in = 1'b0;
    wait_cap(1'b0, n);
    check("stuck_release", n, 3, 0);

    // Reset mid-count aborts immediately
    repeat (50) @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    check("abort_rst_cap", int'(rst_cap), 1, 0);
    check("abort_result", int'(register_out), 0, 0);
    #10;
    rst = 1'b0;
    wait_cap(1'b0, n);
    check("abort_restart", n, DC + 1, 0);
    conversion("after_abort", 1010, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ttd.md
TTD -- requirements
Module: ttd

Interface
REQ-001 Parameter: WIDTH, default 9, internal counter width; captured result is WIDTH-1 bits; legal WIDTH >= 2.
REQ-002 Parameter: DISCHARGE_CYCLES, default 8, minimum clocks rst_cap stays high per conversion; legal >= 1.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: in  input  1  comparator output, asynchronous to clk; 1 = capacitor reached threshold.
REQ-006 Port: rst_cap  output  1  capacitor discharge control; 1 = discharge/hold, 0 = allow charging.
REQ-007 Port: register_out  output  WIDTH-1  last conversion result, clock-cycle count of charge time.

Function
REQ-008 in SHALL pass through a 2-flop synchronizer (in_s); only in_s is used internally, adding 2 cycles of latency.
REQ-009 FSM SHALL have two states: DISCHARGE and COUNT; rst_cap SHALL be a registered output, 1 in DISCHARGE and 0 in COUNT.
REQ-010 DISCHARGE: counter held at 0; discharge timer counts cycles in state.
REQ-011 DISCHARGE -> COUNT when discharge timer has reached DISCHARGE_CYCLES and in_s == 0; if in_s stays 1, remain in DISCHARGE.
REQ-012 COUNT: WIDTH-bit counter SHALL increment by 1 each clock, starting from 0 on the first COUNT cycle.
REQ-013 COUNT with in_s == 1 and counter MSB == 0: register_out <= counter[WIDTH-2:0] on that edge; next state DISCHARGE.
REQ-014 Overflow: COUNT with counter MSB == 1 and in_s == 0: register_out <= all ones (2^(WIDTH-1)-1); next state DISCHARGE.
REQ-015 in_s == 1 on the same edge the MSB sets: overflow rule REQ-014 applies (result saturates to all ones).
REQ-016 register_out SHALL change only on a capture edge (REQ-013/014) or reset, holding its value between conversions.
REQ-017 Conversions SHALL repeat continuously without any external trigger after reset is released.
REQ-018 Transfer: a rise of in t ns after rst_cap falls yields register_out ~= floor(t/Tclk) + 2, tolerance +/-1 for synchronizer phase.
REQ-019 Glitches on in during DISCHARGE SHALL be ignored; only in_s during COUNT ends a conversion.

Reset
REQ-020 While rst == 1, immediately and without a clock: state = DISCHARGE, rst_cap = 1, counter = 0, discharge timer = 0, synchronizer flops = 0, register_out = 0.
REQ-021 After rst falls, the first conversion SHALL start only after the full DISCHARGE_CYCLES discharge.
REQ-022 rst asserted mid-COUNT SHALL abort the conversion with no capture; register_out = 0.

Verification
REQ-023 Power-up: rst = 1 for 100 ns, in = 0 -> rst_cap = 1 and register_out = 0 during reset; rst_cap falls DISCHARGE_CYCLES+1 clocks after release.
REQ-024 Short charge: WIDTH = 9, clk 40 MHz; after rst_cap falls, in = 1 at +3260 ns; in = 0 once rst_cap rises -> register_out = 0x84 +/-1.
REQ-025 Middle charge: same setup, in rises at +4305 ns -> register_out = 0xAE +/-1; value holds through the next DISCHARGE.
REQ-026 Long charge: same setup, in rises at +5350 ns -> register_out = 0xD8 +/-1.
REQ-027 No threshold: in held 0 -> after 256 COUNT cycles, register_out = 0xFF and rst_cap = 1; next conversion starts automatically.
REQ-028 Stuck input and reset abort:
- in held 1 through DISCHARGE -> rst_cap stays 1 until in falls.
- rst pulse mid-COUNT -> rst_cap = 1 and register_out = 0 immediately.
